// File: rtl/frogger_pkg.sv
// ---------------------------------------------------------------------------
// frogger_pkg
// Shared definitions for the frogger game blocks.
//   - Direction codes carried on move commands (UP, DOWN, LEFT, RIGHT).
//   - State encodings for the move arbiter FSM.
// ---------------------------------------------------------------------------
package frogger_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    St_Idle     = 2'b00,
    St_Grant    = 2'b01,
    St_Cooldown = 2'b10
  } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational 4-way round-robin selector.
// Ports:
//   req     in  4  request vector, one bit per requester
//   last    in  2  index of the most recent grant
//   gnt_idx out 2  winning index, searched from last+1 upward (mod 4)
//   any     out 1  at least one request is present
// When no request is present gnt_idx is 0 and must be ignored.
// ---------------------------------------------------------------------------
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       any
);

  logic       w_found;
  logic [1:0] w_idx;

  // Walk the four candidates starting just after the last winner. The most
  // recent winner is checked last, which gives it the lowest priority.
  always_comb begin
    gnt_idx = 2'd0;
    w_found = 1'b0;
    w_idx   = 2'd0;
    any     = |req;
    for (int k = 1; k <= 4; k++) begin
      w_idx = last + 2'(k);
      if (!w_found && req[w_idx]) begin
        gnt_idx = w_idx;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frog_move_arbiter.sv
// ---------------------------------------------------------------------------
// frog_move_arbiter
// Collects one-cycle direction pulses as pending requests, picks one by
// round-robin and presents it to the frog position logic over valid/ack.
// After every accepted move a cooldown window blocks further moves.
// Ports:
//   C_CLOCK_50   in  1  system clock
//   C_Reset      in  1  asynchronous active-high reset
//   C_Enable     in  1  game running; low clears pending and ignores pulses
//   C_Dir_Pulse  in  4  press pulses, bit0=UP bit1=DOWN bit2=LEFT bit3=RIGHT
//   C_Move_Ack   in  1  position logic accepts the presented move
//   C_Move_Valid out 1  a move command is presented
//   C_Move_Dir   out 2  direction code of the presented move
//   C_Busy       out 1  high during GRANT or COOLDOWN
//   C_Pending    out 4  pending request register
// ---------------------------------------------------------------------------
module frog_move_arbiter
  import frogger_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 2_500_000,
  parameter int CNT_W           = 22
) (
  input  logic       C_CLOCK_50,
  input  logic       C_Reset,
  input  logic       C_Enable,
  input  logic [3:0] C_Dir_Pulse,
  input  logic       C_Move_Ack,
  output logic       C_Move_Valid,
  output logic [1:0] C_Move_Dir,
  output logic       C_Busy,
  output logic [3:0] C_Pending
);

  arb_state_t       r_state;
  logic [3:0]       r_pending;
  logic [1:0]       r_last;
  logic [1:0]       r_dir;
  logic [CNT_W-1:0] r_cnt;

  arb_state_t       w_nextState;
  logic [1:0]       w_nextLast;
  logic [1:0]       w_nextDir;
  logic [CNT_W-1:0] w_nextCnt;
  logic [3:0]       w_clear;
  logic [1:0]       w_gnt;
  logic             w_any;

  rr_pick4 u_pick (
    .req     (r_pending),
    .last    (r_last),
    .gnt_idx (w_gnt),
    .any     (w_any)
  );

  // State, winner and cooldown counter registers.
  always_ff @(posedge C_CLOCK_50 or posedge C_Reset) begin
    if (C_Reset) begin
      r_state <= St_Idle;
      r_last  <= DIR_RIGHT;
      r_dir   <= DIR_UP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_last  <= w_nextLast;
      r_dir   <= w_nextDir;
      r_cnt   <= w_nextCnt;
    end
  end

  // Next-state logic. An in-flight grant always waits for its ack, even if
  // the game is disabled meanwhile, so a move is never half-delivered.
  always_comb begin
    w_nextState = r_state;
    w_nextLast  = r_last;
    w_nextDir   = r_dir;
    w_nextCnt   = r_cnt;
    w_clear     = 4'b0000;
    case (r_state)
      St_Idle: begin
        if (C_Enable && w_any) begin
          w_nextDir   = w_gnt;
          w_nextLast  = w_gnt;
          w_nextState = St_Grant;
        end
      end
      St_Grant: begin
        if (C_Move_Ack) begin
          w_clear[r_dir] = 1'b1;
          w_nextCnt      = CNT_W'(COOLDOWN_CYCLES - 1);
          w_nextState    = St_Cooldown;
        end
      end
      St_Cooldown: begin
        if (r_cnt == '0) begin
          w_nextState = St_Idle;
        end else begin
          w_nextCnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_nextState = St_Idle;
      end
    endcase
  end

  // Pending requests: a new pulse wins over a simultaneous clear so a press
  // landing on the ack cycle is not lost.
  always_ff @(posedge C_CLOCK_50 or posedge C_Reset) begin
    if (C_Reset) begin
      r_pending <= 4'b0000;
    end else if (!C_Enable) begin
      r_pending <= 4'b0000;
    end else begin
      r_pending <= (r_pending & ~w_clear) | C_Dir_Pulse;
    end
  end

  assign C_Move_Valid = (r_state == St_Grant);
  assign C_Busy       = (r_state == St_Grant) || (r_state == St_Cooldown);
  assign C_Move_Dir   = r_dir;
  assign C_Pending    = r_pending;

endmodule
